// File: rtl/reorder_buffer_if.sv
// Port bundle between the reorder buffer and the rest of the Tomasulo core.
// Handshake: an issue transfers on a clock edge where issue_valid && issue_ready. cdb_valid is a one-cycle broadcast with no back-pressure.
interface reorder_buffer_if #(parameter int TAG_W = 5);
  logic              issue_valid;
  logic [1:0]        issue_type;
  logic [4:0]        issue_rd;
  logic              issue_pred_taken;
  logic [31:0]       issue_alt_pc;
  logic              issue_ready;
  logic [TAG_W-1:0]  issue_tag;
  logic              dep_set_en;
  logic [4:0]        dep_reg;
  logic [TAG_W-1:0]  dep_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [31:0]       cdb_val;
  logic              cdb_taken;
  logic [TAG_W-1:0]  query1_tag;
  logic [TAG_W-1:0]  query2_tag;
  logic              query1_ready;
  logic              query2_ready;
  logic [31:0]       query1_val;
  logic [31:0]       query2_val;
  logic              commit_en;
  logic [TAG_W-1:0]  commit_tag;
  logic [4:0]        commit_rd;
  logic [31:0]       commit_val;
  logic              store_commit_en;
  logic [TAG_W-1:0]  store_commit_tag;
  logic              flush;
  logic [31:0]       redirect_pc;

  modport master (
    output issue_valid, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
    output cdb_valid, cdb_tag, cdb_val, cdb_taken, query1_tag, query2_tag,
    input  issue_ready, issue_tag, dep_set_en, dep_reg, dep_tag,
    input  query1_ready, query2_ready, query1_val, query2_val,
    input  commit_en, commit_tag, commit_rd, commit_val,
    input  store_commit_en, store_commit_tag, flush, redirect_pc
  );

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
    input  cdb_valid, cdb_tag, cdb_val, cdb_taken, query1_tag, query2_tag,
    output issue_ready, issue_tag, dep_set_en, dep_reg, dep_tag,
    output query1_ready, query2_ready, query1_val, query2_val,
    output commit_en, commit_tag, commit_rd, commit_val,
    output store_commit_en, store_commit_tag, flush, redirect_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags at issue, captures CDB results,
// retires the head in program order and raises a flush on a mispredicted branch.
module reorder_buffer #(
  parameter int TAG_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  reorder_buffer_if.slave rob
);
  localparam int DEPTH = 1 << TAG_W;
  localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ONE  = 1;
  localparam logic [TAG_W-1:0] PTR_ONE  = 1;

  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;
  logic             busy  [DEPTH];
  logic             rdy   [DEPTH];
  logic [1:0]       typ   [DEPTH];
  logic [4:0]       rd    [DEPTH];
  logic [31:0]      val   [DEPTH];
  logic             pred  [DEPTH];
  logic             taken [DEPTH];
  logic [31:0]      alt_pc[DEPTH];

  logic       issue_acc, do_commit, mispredict;
  logic [1:0] issue_t;

  // Reserved type 3 behaves like an ordinary register-writing op.
  assign issue_t     = (rob.issue_type == 2'd3) ? 2'd0 : rob.issue_type;
  assign rob.issue_ready = (count != CNT_FULL) && !rob.flush;
  assign issue_acc   = rob.issue_valid && rob.issue_ready;
  assign rob.issue_tag   = tail;
  assign rob.dep_set_en  = issue_acc && (issue_t == 2'd0) && (rob.issue_rd != 5'd0);
  assign rob.dep_reg     = rob.issue_rd;
  assign rob.dep_tag     = tail;
  assign do_commit   = (count != '0) && busy[head] && rdy[head];
  assign mispredict  = do_commit && (typ[head] == 2'd2) && (taken[head] != pred[head]);

  // Operand lookup: stored result first, then same-cycle CDB bypass.
  always_comb begin
    rob.query1_ready = 1'b0;
    rob.query1_val   = '0;
    rob.query2_ready = 1'b0;
    rob.query2_val   = '0;
    if (busy[rob.query1_tag] && rdy[rob.query1_tag]) begin
      rob.query1_ready = 1'b1;
      rob.query1_val   = val[rob.query1_tag];
    end else if (rob.cdb_valid && rob.cdb_tag == rob.query1_tag) begin
      rob.query1_ready = 1'b1;
      rob.query1_val   = rob.cdb_val;
    end
    if (busy[rob.query2_tag] && rdy[rob.query2_tag]) begin
      rob.query2_ready = 1'b1;
      rob.query2_val   = val[rob.query2_tag];
    end else if (rob.cdb_valid && rob.cdb_tag == rob.query2_tag) begin
      rob.query2_ready = 1'b1;
      rob.query2_val   = rob.cdb_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head                 <= '0;
      tail                 <= '0;
      count                <= '0;
      rob.commit_en        <= 1'b0;
      rob.commit_tag       <= '0;
      rob.commit_rd        <= '0;
      rob.commit_val       <= '0;
      rob.store_commit_en  <= 1'b0;
      rob.store_commit_tag <= '0;
      rob.flush            <= 1'b0;
      rob.redirect_pc      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        busy[i] <= 1'b0;
        rdy[i]  <= 1'b0;
      end
    end else begin
      rob.commit_en       <= 1'b0;
      rob.store_commit_en <= 1'b0;
      rob.flush           <= 1'b0;

      if (issue_acc) begin
        busy[tail]   <= 1'b1;
        rdy[tail]    <= (issue_t == 2'd1);
        typ[tail]    <= issue_t;
        rd[tail]     <= rob.issue_rd;
        pred[tail]   <= rob.issue_pred_taken;
        alt_pc[tail] <= rob.issue_alt_pc;
        tail         <= tail + PTR_ONE;
      end

      if (rob.cdb_valid && busy[rob.cdb_tag]) begin
        val[rob.cdb_tag]   <= rob.cdb_val;
        taken[rob.cdb_tag] <= rob.cdb_taken;
        rdy[rob.cdb_tag]   <= 1'b1;
      end

      if (do_commit) begin
        busy[head] <= 1'b0;
        rdy[head]  <= 1'b0;
        head       <= head + PTR_ONE;
        case (typ[head])
          2'd0: begin
            rob.commit_en  <= 1'b1;
            rob.commit_tag <= head;
            rob.commit_rd  <= rd[head];
            rob.commit_val <= val[head];
          end
          2'd1: begin
            rob.store_commit_en  <= 1'b1;
            rob.store_commit_tag <= head;
          end
          default: ;
        endcase
      end

      case ({issue_acc, do_commit})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase

      // Mispredict wins over every update above, including this cycle's issue.
      if (mispredict) begin
        rob.flush       <= 1'b1;
        rob.redirect_pc <= alt_pc[head];
        head            <= '0;
        tail            <= '0;
        count           <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          busy[i] <= 1'b0;
          rdy[i]  <= 1'b0;
        end
      end
    end
  end
endmodule
